vip_stream_out: RTL
===================

# vip_stream_out

Downstream consumer of `vip_top`'s output FIFO. Drains the pixel FIFO with a 1-cycle-latency read handshake and re-emits pixels as a valid/ready stream with start-of-frame, end-of-line and end-of-frame markers derived from the frame geometry. It replaces direct FIFO polling by `ImageWriter`-style sinks and by downstream display/DMA stages.

## Interface
- `DWIDTH`, 24, pixel width in bits (RGB888)
- `DIM_W`, 11, width of the `width`, `height` and `num_frame` fields
- `clock` in 1: single clock domain.
- `reset` in 1: synchronous, active-low.
- `enable` in 1: level; starts a run when sampled high in IDLE.
- `width` in DIM_W: pixels per line; latched at run start.
- `height` in DIM_W: lines per frame; latched at run start.
- `num_frame` in DIM_W: frames per run; latched at run start.
- `fifo_data` in DWIDTH: FIFO read data, valid the cycle after `fifo_rdreq`.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_rdreq` out 1: FIFO read request.
- `m_data` out DWIDTH: stream pixel.
- `m_valid` out 1: stream valid.
- `m_ready` in 1: stream ready.
- `m_sof` out 1: first pixel of a frame; qualified by `m_valid`.
- `m_eol` out 1: last pixel of a line; qualified by `m_valid`.
- `m_eof` out 1: last pixel of a frame; qualified by `m_valid`.
- `busy` out 1: high while not IDLE.
- `run_done` out 1: 1-cycle pulse after the last pixel of the last frame is accepted.
- `cfg_err` out 1: 1-cycle pulse when a run is rejected.

## Operation
- **Reset values:** all outputs are 0 while `reset`=0. The state machine, counters and buffer are cleared, and any in-flight FIFO word is discarded. The external FIFO is not reset by this block.
- **IDLE**
  - With `enable`=1 and `width`, `height` and `num_frame` all nonzero: latch the configuration, clear counters and go to RUN.
  - If any of the three is zero: pulse `cfg_err` and stay in IDLE.
- **RUN**
  - Request side:
    - `fifo_rdreq = !fifo_empty && (buf_count + inflight) < 3 && !req_frame_done`.
    - `inflight` is a 1-bit register equal to the previous cycle's `fifo_rdreq`.
    - Request counters `rx`/`ry` advance per read. `req_frame_done` sets after the `width*height`-th read of the frame.
  - Capture: when `inflight`=1, push `fifo_data` into the 3-entry register buffer.
  - Output side:
    - `m_valid = buf_count != 0`. `m_data` is the buffer head.
    - On each handshake (`m_valid && m_ready`), pop the head and advance output counters `ox`/`oy`.
  - Markers:
    - `m_sof` = (`ox`==0 && `oy`==0).
    - `m_eol` = (`ox`==`width`-1).
    - `m_eof` = `m_eol` && (`oy`==`height`-1).
  - End of frame: on a handshake with `m_eof`=1, increment `fcnt`.
    - If `fcnt`+1==`num_frame`: go to IDLE and pulse `run_done`.
    - Otherwise: clear `rx`/`ry`/`ox`/`oy` and `req_frame_done`, and stay in RUN.
    - `req_frame_done` is already set at this point, so the buffer is empty and no pixels cross a frame boundary.
- `enable` is ignored outside IDLE. Configuration changes during a run have no effect.
- The block never over-reads: at most `width*height` reads per frame.
- **Width rule:** 1×1 frames are legal. In that case `m_sof`, `m_eol` and `m_eof` are all high on the same beat.

## Timing
- Read latency: `fifo_rdreq` in cycle t, then `fifo_data` captured at the end of t+1, then `m_valid` high in cycle t+2.
- First pixel of a run: `m_valid` no earlier than 3 cycles after `enable` is sampled (IDLE→RUN, then rdreq, then capture).
- Sustained 1 pixel/cycle with `m_ready`=1 and a non-empty FIFO.
- No combinational path from `m_ready` to `fifo_rdreq`. `m_data`/`m_valid` and the markers come from registers and counters only.
- AXI-style stream rules:
  - `m_valid` stays high until the beat is accepted.
  - `m_data` and the markers are stable while stalled.
- Buffer push and pop in the same cycle: `buf_count` is unchanged.
- `fifo_empty` rising while a read is in flight: the in-flight word is still captured and the next request is held.
- `reset` low mid-frame: on the next edge all outputs are 0 and the state is IDLE.

## Structure
- `vip_stream_pkg`:
  - state enum (IDLE, RUN)
  - `DIM_W` default
  - buffer depth constant `OUT_BUF_DEPTH`=3
- Sub-module `vip_skid_fifo3`: 3-entry register FIFO with push, pop, count, head and synchronous active-low reset.
- Top level holds the FSM, request/output counters and marker logic.

## Test plan
- 4×2 frame, `num_frame`=1, FIFO preloaded with 8 words, `m_ready`=1 → 8 beats on consecutive cycles. `m_sof` on beat 0, `m_eol` on beats 3 and 7, `m_eof` on beat 7. `run_done` the cycle after beat 7. Exactly 8 rdreqs.
- Same frame with `m_ready` toggling 1010… → data order preserved, `m_data` stable during stalls, `buf_count` never exceeds 3.
- 3×3 frame, `num_frame`=2, 20 words preloaded → exactly 18 reads (2 words remain in the FIFO), `m_sof` on beats 0 and 9, `busy` falls after beat 17.
- `enable`=1 with `width`=0 → `cfg_err` pulses 1 cycle, `busy` stays 0, no rdreq.
- FIFO empty for 5 cycles mid-line → `fifo_rdreq`=0 while empty, `ox` resumes without skipping.
- `reset`=0 after pixel 5 of a 4×4 frame → all outputs are 0 on the next edge. A new `enable` restarts at `m_sof`.

Source files
------------

// File: rtl/vip_stream_pkg.sv
// Shared types and constants for the vip_stream_out pixel stream egress block.
package vip_stream_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DIM_W_DEFAULT  = 11;
    localparam int DWIDTH_DEFAULT = 24;
    localparam int OUT_BUF_DEPTH  = 3;
    localparam int BUF_CNT_W      = 2;

endpackage

// File: rtl/vip_skid_fifo3.sv
// Three-entry register FIFO; the head entry always sits in slot 0 so the
// stream output is a plain register read.
module vip_skid_fifo3
    import vip_stream_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DWIDTH-1:0]    din,
    output logic [DWIDTH-1:0]    head,
    output logic [BUF_CNT_W-1:0] count
);

    localparam logic [BUF_CNT_W-1:0] CNT_FULL = BUF_CNT_W'(OUT_BUF_DEPTH);
    localparam logic [BUF_CNT_W-1:0] CNT_ONE  = {{(BUF_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [BUF_CNT_W-1:0] CNT_ZERO = {BUF_CNT_W{1'b0}};

    logic [DWIDTH-1:0]    mem_r      [OUT_BUF_DEPTH];
    logic [DWIDTH-1:0]    mem_next_s [OUT_BUF_DEPTH];
    logic [BUF_CNT_W-1:0] count_r;
    logic [BUF_CNT_W-1:0] count_next_s;
    logic [BUF_CNT_W-1:0] wr_idx_s;
    logic                 pop_ok_s;
    logic                 push_ok_s;

    // Next storage image: shift on pop, then write the new word behind the last valid entry.
    always_comb begin
        pop_ok_s   = pop && (count_r != CNT_ZERO);
        push_ok_s  = push && ((count_r != CNT_FULL) || pop_ok_s);
        mem_next_s = mem_r;
        if (pop_ok_s) begin
            for (int i = 0; i < OUT_BUF_DEPTH - 1; i++) begin
                mem_next_s[i] = mem_r[i+1];
            end
            mem_next_s[OUT_BUF_DEPTH-1] = {DWIDTH{1'b0}};
            wr_idx_s = count_r - CNT_ONE;
        end else begin
            wr_idx_s = count_r;
        end
        for (int i = 0; i < OUT_BUF_DEPTH; i++) begin
            mem_next_s[i] = (push_ok_s && (wr_idx_s == BUF_CNT_W'(i))) ? din : mem_next_s[i];
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // Storage and occupancy registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < OUT_BUF_DEPTH; i++) begin
                mem_r[i] <= {DWIDTH{1'b0}};
            end
            count_r <= CNT_ZERO;
        end else begin
            mem_r   <= mem_next_s;
            count_r <= count_next_s;
        end
    end

    assign head  = mem_r[0];
    assign count = count_r;

endmodule

// File: rtl/vip_stream_out.sv
// Drains the pixel FIFO (1-cycle read latency) and re-emits pixels as a
// valid/ready stream with SOF/EOL/EOF markers derived from the frame geometry.
module vip_stream_out
    import vip_stream_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEFAULT,
    parameter int DIM_W  = DIM_W_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [DIM_W-1:0]  width,
    input  logic [DIM_W-1:0]  height,
    input  logic [DIM_W-1:0]  num_frame,
    input  logic [DWIDTH-1:0] fifo_data,
    input  logic              fifo_empty,
    output logic              fifo_rdreq,
    output logic [DWIDTH-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_sof,
    output logic              m_eol,
    output logic              m_eof,
    output logic              busy,
    output logic              run_done,
    output logic              cfg_err
);

    localparam logic [DIM_W-1:0]     DIM_ZERO  = {DIM_W{1'b0}};
    localparam logic [DIM_W-1:0]     DIM_ONE   = {{(DIM_W-1){1'b0}}, 1'b1};
    localparam logic [BUF_CNT_W:0]   OCC_LIMIT = (BUF_CNT_W+1)'(OUT_BUF_DEPTH);
    localparam logic [BUF_CNT_W-1:0] CNT_ZERO  = {BUF_CNT_W{1'b0}};

    state_t               state_r;
    state_t               state_next_s;
    logic [DIM_W-1:0]     width_r;
    logic [DIM_W-1:0]     height_r;
    logic [DIM_W-1:0]     nframe_r;
    logic [DIM_W-1:0]     rx_r;
    logic [DIM_W-1:0]     ry_r;
    logic [DIM_W-1:0]     ox_r;
    logic [DIM_W-1:0]     oy_r;
    logic [DIM_W-1:0]     fcnt_r;
    logic                 req_done_r;
    logic                 inflight_r;
    logic                 run_done_r;
    logic                 cfg_err_r;

    logic [DWIDTH-1:0]    head_s;
    logic [BUF_CNT_W-1:0] buf_count_s;
    logic [BUF_CNT_W:0]   occupancy_s;
    logic                 cfg_ok_s;
    logic                 rdreq_s;
    logic                 valid_s;
    logic                 hs_s;
    logic                 rx_last_s;
    logic                 ry_last_s;
    logic                 ox_last_s;
    logic                 oy_last_s;
    logic                 sof_s;
    logic                 eol_s;
    logic                 eof_s;
    logic                 frame_end_s;
    logic                 last_frame_s;

    vip_skid_fifo3 #(
        .DWIDTH (DWIDTH)
    ) u_buf (
        .clock (clock),
        .reset (reset),
        .push  (inflight_r),
        .pop   (hs_s),
        .din   (fifo_data),
        .head  (head_s),
        .count (buf_count_s)
    );

    // Words already in the buffer plus the one in flight bound the request,
    // so a word requested now always has a slot when it lands.
    assign cfg_ok_s     = (width != DIM_ZERO) && (height != DIM_ZERO) && (num_frame != DIM_ZERO);
    assign occupancy_s  = {1'b0, buf_count_s} + {{BUF_CNT_W{1'b0}}, inflight_r};
    assign rdreq_s      = (state_r == ST_RUN) && !fifo_empty && (occupancy_s < OCC_LIMIT) && !req_done_r;
    assign valid_s      = (buf_count_s != CNT_ZERO);
    assign hs_s         = valid_s && m_ready;
    assign rx_last_s    = (rx_r == width_r - DIM_ONE);
    assign ry_last_s    = (ry_r == height_r - DIM_ONE);
    assign ox_last_s    = (ox_r == width_r - DIM_ONE);
    assign oy_last_s    = (oy_r == height_r - DIM_ONE);
    assign sof_s        = valid_s && (ox_r == DIM_ZERO) && (oy_r == DIM_ZERO);
    assign eol_s        = valid_s && ox_last_s;
    assign eof_s        = eol_s && oy_last_s;
    assign frame_end_s  = hs_s && eof_s;
    assign last_frame_s = ((fcnt_r + DIM_ONE) == nframe_r);

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable && cfg_ok_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (frame_end_s && last_frame_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Configuration latch, request/output counters and status pulses.
    always_ff @(posedge clock) begin
        if (!reset) begin
            width_r    <= DIM_ZERO;
            height_r   <= DIM_ZERO;
            nframe_r   <= DIM_ZERO;
            rx_r       <= DIM_ZERO;
            ry_r       <= DIM_ZERO;
            ox_r       <= DIM_ZERO;
            oy_r       <= DIM_ZERO;
            fcnt_r     <= DIM_ZERO;
            req_done_r <= 1'b0;
            inflight_r <= 1'b0;
            run_done_r <= 1'b0;
            cfg_err_r  <= 1'b0;
        end else begin
            inflight_r <= rdreq_s;
            cfg_err_r  <= (state_r == ST_IDLE) && enable && !cfg_ok_s;
            run_done_r <= (state_r == ST_RUN) && frame_end_s && last_frame_s;
            case (state_r)
                ST_IDLE: begin
                    if (enable && cfg_ok_s) begin
                        width_r    <= width;
                        height_r   <= height;
                        nframe_r   <= num_frame;
                        rx_r       <= DIM_ZERO;
                        ry_r       <= DIM_ZERO;
                        ox_r       <= DIM_ZERO;
                        oy_r       <= DIM_ZERO;
                        fcnt_r     <= DIM_ZERO;
                        req_done_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (rdreq_s) begin
                        if (rx_last_s) begin
                            rx_r <= DIM_ZERO;
                            ry_r <= ry_r + DIM_ONE;
                            if (ry_last_s) begin
                                req_done_r <= 1'b1;
                            end
                        end else begin
                            rx_r <= rx_r + DIM_ONE;
                        end
                    end
                    // req_done is set here, so no read competes with the frame restart.
                    if (frame_end_s) begin
                        fcnt_r     <= fcnt_r + DIM_ONE;
                        rx_r       <= DIM_ZERO;
                        ry_r       <= DIM_ZERO;
                        ox_r       <= DIM_ZERO;
                        oy_r       <= DIM_ZERO;
                        req_done_r <= 1'b0;
                    end else if (hs_s) begin
                        if (ox_last_s) begin
                            ox_r <= DIM_ZERO;
                            oy_r <= oy_r + DIM_ONE;
                        end else begin
                            ox_r <= ox_r + DIM_ONE;
                        end
                    end
                end
                default: begin
                    req_done_r <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_rdreq = rdreq_s;
    assign m_data     = head_s;
    assign m_valid    = valid_s;
    assign m_sof      = sof_s;
    assign m_eol      = eol_s;
    assign m_eof      = eof_s;
    assign busy       = (state_r == ST_RUN);
    assign run_done   = run_done_r;
    assign cfg_err    = cfg_err_r;

endmodule
